soc_system_aes_job_ctrl: RTL and testbench
==========================================

// Module: soc_system_aes_job_ctrl
// PURPOSE
//  Avalon-MM slave that sequences one AES core: holds a 128-bit input block and launches the core.
//  Captures the 128-bit result, reports status and arbitrates between two start sources:
//  software (CTRL.START) and the external FPGA trigger pin (hw_trig).
//  Sits between the HPS lightweight bridge and the AES datapath.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  WAIT-state cycle limit before TIMEOUT is flagged; 0 = timeout disabled
//  CNT_W           16    width of JOB_COUNT; wraps modulo 2^CNT_W
// PORTS
//  clk         in   1    system clock; the only clock
//  reset       in   1    synchronous, active-high reset
//  address     in   4    Avalon word address
//  read        in   1    Avalon read strobe
//  write       in   1    Avalon write strobe
//  writedata   in   32   Avalon write data
//  readdata    out  32   registered read data, 1-cycle latency
//  hw_trig     in   1    asynchronous trigger pin; rising edge requests a job
//  core_din    out  128  input block to core, stable from LAUNCH until return to IDLE
//  core_start  out  1    1-cycle start pulse to core
//  core_done   in   1    1-cycle completion pulse from core
//  core_dout   in   128  core result, valid in the core_done cycle
//  irq         out  1    level interrupt; present only with AES_JOB_CTRL_IRQ_EN
// BEHAVIOUR
//  Reset: all registers, readdata, core_start, irq and FSM (IDLE) = 0; sync flops and pending flag cleared.
//  Register map (word address):
//   0 CTRL    W: b0 START (self-clearing), b3 ABORT (self-clearing); RW: b1 HW_TRIG_EN, b2 IRQ_EN.
//             Reads b0/b3 as 0.
//   1 STATUS  RO: b0 BUSY, b3 SRC (source of last launched job, 0 = sw, 1 = hw).
//             W1C sticky: b1 DONE, b2 TIMEOUT, b4 OVERRUN.
//   2..5 DIN0..3   RW; DIN0 = bits[31:0].
//   6..9 DOUT0..3  RO.
//   10 JOB_COUNT   RO; zero-extended.
//   11..15         read 0, writes ignored.
//  Reads: readdata updates on the cycle after read is asserted; otherwise it holds its value. No waitrequest.
//  hw_trig: 2-FF synchroniser plus edge detect, giving 3 cycles pin-to-request.
//   Edges are ignored when HW_TRIG_EN = 0.
//  FSM:
//   IDLE: a request moves to LAUNCH and sets SRC.
//    SW request = write of CTRL.START = 1. HW request = synced edge or pending flag.
//    SW and HW in the same cycle: SW wins; the HW request is stored as pending.
//   LAUNCH (1 cycle): core_din <= {DIN3..DIN0} snapshot; core_start = 1 for this cycle only; then WAIT.
//   WAIT: wait counter increments every cycle.
//    core_done = 1: DOUT <= core_dout, DONE <= 1, JOB_COUNT++ (wraps), go to IDLE.
//    Counter == TIMEOUT_CYCLES-1 without core_done: TIMEOUT <= 1, DOUT unchanged, go to IDLE.
//    ABORT written: go to IDLE, no flags set.
//    core_done and ABORT in the same cycle: core_done wins.
//  BUSY = (state != IDLE).
//  core_done while IDLE or LAUNCH (late, stray, or after abort) is ignored.
//  SW START while BUSY is dropped silently.
//  HW edge while BUSY: sets pending if pending is clear; otherwise OVERRUN <= 1. Pending depth is 1.
//  DIN writes while BUSY are accepted; the in-flight job uses its snapshot.
//  W1C write and a same-cycle set of the same bit: the set wins.
//  Reset mid-job: FSM returns to IDLE, pending cleared; core sees no further start.
//  Worst-case latency, START write to core_start: 1 cycle after the write is accepted.
// CONFIGURATION
//  AES_JOB_CTRL_IRQ_EN defined:
//   irq = CTRL.IRQ_EN & (DONE | TIMEOUT | OVERRUN), registered (1 cycle after the flag sets).
//   Cleared by W1C of the causing flags.
//  AES_JOB_CTRL_IRQ_EN undefined:
//   irq port and CTRL.IRQ_EN storage are absent; CTRL b2 reads 0; all other behaviour identical.
// TESTING
//  Reset then read all addresses -> every register reads 0, BUSY = 0, core_start never asserted.
//  DIN = 0x00112233_44556677_8899AABB_CCDDEEFF, write CTRL = 0x1, core_done 10 cycles after start
//   with core_dout = 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A
//   -> one core_start pulse; DOUT0..3 match; STATUS = 0x2; JOB_COUNT = 1.
//  TIMEOUT_CYCLES = 16, start, no core_done -> STATUS.TIMEOUT = 1 after 16 WAIT cycles.
//   A core_done arriving later is ignored: DOUT unchanged, JOB_COUNT unchanged.
//  HW_TRIG_EN = 1; SW START and synced hw edge in the same cycle; a second hw edge during the job;
//   a third edge during the job -> jobs run sw then hw (SRC = 1); OVERRUN = 1; JOB_COUNT += 2.
//  ABORT in WAIT, then core_done 2 cycles later -> BUSY = 0; DONE = 0; next START launches normally.
//  IRQ_EN build: CTRL = 0x4, finish a job -> irq = 1; write STATUS = 0x2 -> irq = 0 the next cycle.

Source files
------------

// File: rtl/soc_system_aes_job_ctrl.sv
// Avalon-MM job sequencer for a single AES core: input block, launch, result capture, status.
// Optional build macro AES_JOB_CTRL_IRQ_EN adds the irq output and the CTRL.IRQ_EN bit.
module soc_system_aes_job_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   address,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    input  logic         hw_trig,
    output logic [127:0] core_din,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_dout
`ifdef AES_JOB_CTRL_IRQ_EN
    ,
    output logic         irq
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic                src_q, src_d;
    logic                pending_q, pending_d;
    logic [31:0]         wait_cnt_q, wait_cnt_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;
    logic [CNT_W-1:0]    job_cnt_q, job_cnt_d;
    logic [3:0][31:0]    din_q;
    logic [127:0]        dout_q;
    logic [127:0]        core_din_q;
    logic                hw_en_q;
    logic                trig_meta_q, trig_sync_q, trig_prev_q;
    logic [31:0]         readdata_q;
    logic [31:0]         rd_mux;
    logic [3:0]          din_we;
    logic                irq_en_bit;
    logic                snap, capture, done_set, timeout_set, overrun_set;

    wire       ctrl_wr    = write && (address == 4'd0);
    wire       status_wr  = write && (address == 4'd1);
    wire       sw_start   = ctrl_wr && writedata[0];
    wire       abort_wr   = ctrl_wr && writedata[3];
    wire       hw_edge    = hw_en_q && trig_sync_q && !trig_prev_q;
    wire       busy       = (state_q != ST_IDLE);
    wire [1:0] word_idx   = address[1:0] - 2'd2;

    // DIN0..3 live at 2..5; word_idx also maps DOUT0..3 at 6..9 onto 0..3.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_din_we
            assign din_we[gi] = write && (address == 4'(gi + 2));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        pending_d   = pending_q;
        wait_cnt_d  = wait_cnt_q;
        snap        = 1'b0;
        capture     = 1'b0;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        overrun_set = 1'b0;
        // A hardware edge that cannot launch right away is parked; a second one overflows.
        if (hw_edge && (busy || sw_start)) begin
            if (pending_q) overrun_set = 1'b1;
            else           pending_d   = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (sw_start) begin
                    state_d = ST_LAUNCH;
                    src_d   = 1'b0;
                    snap    = 1'b1;
                end else if (pending_q || hw_edge) begin
                    state_d   = ST_LAUNCH;
                    src_d     = 1'b1;
                    snap      = 1'b1;
                    pending_d = pending_q && hw_edge;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (core_done) begin
                    capture  = 1'b1;
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else if (abort_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Same-cycle set beats the write-one-to-clear.
        done_d    = (done_q    && !(status_wr && writedata[1])) || done_set;
        timeout_d = (timeout_q && !(status_wr && writedata[2])) || timeout_set;
        overrun_d = (overrun_q && !(status_wr && writedata[4])) || overrun_set;
        job_cnt_d = capture ? job_cnt_q + CNT_W'(1) : job_cnt_q;
    end

`ifdef AES_JOB_CTRL_IRQ_EN
    logic irq_en_q, irq_q;
    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= writedata[2];
            irq_q <= irq_en_q && (done_q || timeout_q || overrun_q);
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            4'd0:                      rd_mux = {28'd0, 1'b0, irq_en_bit, hw_en_q, 1'b0};
            4'd1:                      rd_mux = {27'd0, overrun_q, src_q, timeout_q, done_q, busy};
            4'd2, 4'd3, 4'd4, 4'd5:    rd_mux = din_q[word_idx];
            4'd6, 4'd7, 4'd8, 4'd9:    rd_mux = dout_q[32*word_idx +: 32];
            4'd10:                     rd_mux = 32'(job_cnt_q);
            default:                   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= 1'b0;
            pending_q   <= 1'b0;
            wait_cnt_q  <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            job_cnt_q   <= '0;
            din_q       <= '0;
            dout_q      <= '0;
            core_din_q  <= '0;
            hw_en_q     <= 1'b0;
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            trig_prev_q <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            job_cnt_q   <= job_cnt_d;
            trig_meta_q <= hw_trig;
            trig_sync_q <= trig_meta_q;
            trig_prev_q <= trig_sync_q;
            if (ctrl_wr) hw_en_q <= writedata[1];
            for (int i = 0; i < 4; i++) begin
                if (din_we[i]) din_q[i] <= writedata;
            end
            if (snap)    core_din_q <= din_q;
            if (capture) dout_q     <= core_dout;
            if (read)    readdata_q <= rd_mux;
        end
    end

    assign readdata   = readdata_q;
    assign core_din   = core_din_q;
    assign core_start = (state_q == ST_LAUNCH);
endmodule

// File: tb/tb_soc_system_aes_job_ctrl.sv
// Scoreboard bench for soc_system_aes_job_ctrl: reads and launches are checked by a monitor
// against expectations queued by the stimulus from a register-level model.
module tb_soc_system_aes_job_ctrl;
    localparam int TC = 16;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   address;
    logic         read, write;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         hw_trig;
    logic [127:0] core_din;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_dout;
`ifdef AES_JOB_CTRL_IRQ_EN
    logic         irq;
`endif

    soc_system_aes_job_ctrl #(.TIMEOUT_CYCLES(TC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .hw_trig(hw_trig),
        .core_din(core_din), .core_start(core_start), .core_done(core_done),
        .core_dout(core_dout)
`ifdef AES_JOB_CTRL_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  rd_exp_q[$];
    string        rd_name_q[$];
    logic [127:0] launch_q[$];
    logic         rd_due = 1'b0;

    // Reference model state
    logic [31:0] m_din[4];
    logic [31:0] m_dout[4];
    int          m_count;
    bit          m_done, m_to, m_ov, m_src, m_hwen;

    always @(posedge clk) rd_due <= read && !reset;

    // Monitor: read data one cycle after the strobe, core_din whenever core_start fires
    always @(negedge clk) begin
        if (rd_due) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h required none", readdata);
            end else begin
                logic [31:0] e;
                string nm;
                e  = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (readdata !== e) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", nm, readdata, e);
                end else
                    $display("read %s = %h", nm, readdata);
            end
        end
        if (core_start === 1'b1) begin
            checks++;
            if (launch_q.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected: core_start with core_din %h, required no start", core_din);
            end else begin
                logic [127:0] e;
                e = launch_q.pop_front();
                if (core_din !== e) begin
                    errors++;
                    $display("FAIL launch_din: got %h required %h", core_din, e);
                end else
                    $display("launch core_din = %h", core_din);
            end
        end
    end

    function automatic logic [31:0] m_status();
        return {27'd0, m_ov, m_src, m_to, m_done, 1'b0};
    endfunction

    function automatic logic [127:0] m_din_vec();
        return {m_din[3], m_din[2], m_din[1], m_din[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        address = a; read = 1'b1;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
        tick();
        read = 1'b0;
    endtask

    task automatic set_din(input logic [127:0] v);
        for (int i = 0; i < 4; i++) begin
            wr(4'(2 + i), v[32*i +: 32]);
            m_din[i] = v[32*i +: 32];
        end
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (core_start === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_wait: got no core_start within 40 cycles, required a start");
        end
    endtask

    // Runs the WAIT phase from the core_start cycle; done pulse lands lat cycles after start.
    task automatic run_wait(input int lat, input logic [127:0] dout,
                            input bit mid_en, input logic [3:0] mid_a, input logic [31:0] mid_d);
        for (int c = 1; c <= lat; c++) begin
            tick();
            write = 1'b0;
            if (mid_en && c == 2) begin
                address = mid_a; writedata = mid_d; write = 1'b1;
            end
            if (c == lat) begin
                core_done = 1'b1; core_dout = dout;
            end
        end
        tick();
        write = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic model_finish(input int lat, input logic [127:0] dout);
        if (lat <= TC) begin
            for (int i = 0; i < 4; i++) m_dout[i] = dout[32*i +: 32];
            m_done  = 1'b1;
            m_count = (m_count + 1) % (1 << CW);
        end else
            m_to = 1'b1;
    endtask

    task automatic sw_job(input int lat, input logic [127:0] dout,
                          input bit mid_en, input logic [3:0] mid_a, input logic [31:0] mid_d);
        launch_q.push_back(m_din_vec());
        wr(4'd0, {30'd0, m_hwen, 1'b1});
        m_src = 1'b0;
        wait_start();
        run_wait(lat, dout, mid_en, mid_a, mid_d);
    endtask

    task automatic check_regs();
        tick();
        rd(4'd1, m_status(), "STATUS");
        for (int i = 0; i < 4; i++) rd(4'(6 + i), m_dout[i], $sformatf("DOUT%0d", i));
        rd(4'd10, 32'(m_count), "JOB_COUNT");
    endtask

    task automatic clear_flags();
        wr(4'd1, 32'h16);
        m_done = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_din[i] = '0; m_dout[i] = '0; end
        m_count = 0; m_done = 0; m_to = 0; m_ov = 0; m_src = 0; m_hwen = 0;
    endtask

    initial begin
        logic [127:0] v, d;
        int lat;
        reset = 1'b1; address = '0; read = 0; write = 0; writedata = '0;
        hw_trig = 0; core_done = 0; core_dout = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state of the full map
        for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, $sformatf("reset_addr%0d", a));
`ifdef AES_JOB_CTRL_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_reset: got %b required 0", irq); end
`endif

        // CTRL readback: START/ABORT read 0, IRQ_EN only present in the irq build
        wr(4'd0, 32'h6);
`ifdef AES_JOB_CTRL_IRQ_EN
        rd(4'd0, 32'h6, "CTRL_rb");
`else
        rd(4'd0, 32'h2, "CTRL_rb");
`endif
        wr(4'd0, 32'h0);

        // Known-answer job, with a dropped START and a DIN write while busy
        set_din(128'h00112233_44556677_8899AABB_CCDDEEFF);
        d = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
        sw_job(10, d, 1'b1, 4'd0, 32'h1);
        model_finish(10, d);
        check_regs();
        sw_job(6, ~d, 1'b1, 4'd2, 32'hA5A5_0001);
        model_finish(6, ~d);
        m_din[0] = 32'hA5A5_0001;
        check_regs();
        rd(4'd2, m_din[0], "DIN0");
        clear_flags();

        // Timeout, then a late core_done is ignored
        sw_job(30, 128'hDEAD, 1'b0, 4'd0, 32'd0);
        model_finish(30, 128'hDEAD);
        check_regs();
        clear_flags();

        // SW and HW in the same cycle, then two more HW edges during the job
        wr(4'd0, 32'h2);
        m_hwen = 1'b1;
        hw_trig = 1'b1;
        tick(); tick();
        launch_q.push_back(m_din_vec());
        launch_q.push_back(m_din_vec());
        wr(4'd0, 32'h3);
        wait_start();
        d = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 1; c <= 14; c++) begin
            tick();
            hw_trig = (c >= 4 && c <= 6) || (c >= 10);
            if (c == 14) begin core_done = 1'b1; core_dout = d; end
        end
        tick();
        core_done = 1'b0;
        model_finish(14, d);
        wait_start();
        d = {$urandom, $urandom, $urandom, $urandom};
        run_wait(5, d, 1'b0, 4'd0, 32'd0);
        model_finish(5, d);
        m_src = 1'b1; m_ov = 1'b1;
        check_regs();
        hw_trig = 1'b0;
        wr(4'd0, 32'h0);
        m_hwen = 1'b0;
        clear_flags();

        // ABORT in WAIT, core_done two cycles later is ignored; next START is normal
        sw_job(4, 128'hBAD, 1'b1, 4'd0, 32'h8);
        repeat (3) tick();
        check_regs();
        d = {$urandom, $urandom, $urandom, $urandom};
        sw_job(3, d, 1'b0, 4'd0, 32'd0);
        model_finish(3, d);
        check_regs();
        clear_flags();

`ifdef AES_JOB_CTRL_IRQ_EN
        wr(4'd0, 32'h4);
        launch_q.push_back(m_din_vec());
        wr(4'd0, 32'h5);
        wait_start();
        run_wait(3, 128'h1234, 1'b0, 4'd0, 32'd0);
        model_finish(3, 128'h1234);
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
        wr(4'd1, 32'h2);
        m_done = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
        wr(4'd0, 32'h0);
`endif

        // Randomised jobs: random DIN, latency on both sides of the timeout, sticky flags
        for (int j = 0; j < 20; j++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            lat = int'($urandom_range(1, 20));
            set_din(v);
            sw_job(lat, d, 1'b0, 4'd0, 32'd0);
            model_finish(lat, d);
            if (lat > TC) repeat (2) tick();
            check_regs();
            rd(4'(2 + (j % 4)), m_din[j % 4], $sformatf("DIN%0d", j % 4));
            if ($urandom_range(0, 1) == 1) clear_flags();
        end

        // Reset mid-job: everything back to zero, later core_done ignored
        launch_q.push_back(m_din_vec());
        wr(4'd0, 32'h1);
        wait_start();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        core_done = 1'b1; core_dout = '1;
        tick();
        core_done = 1'b0;
        check_regs();
        rd(4'd2, 32'd0, "DIN0_after_reset");

        repeat (4) tick();
        checks++;
        if (launch_q.size() != 0 || rd_exp_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got launches=%0d reads=%0d required 0 and 0",
                     launch_q.size(), rd_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish by 2 ms required completion");
        $fatal(1, "bench timeout");
    end
endmodule
